// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size codes, FSM encoding and byte-lane helpers for the load/store unit.
package lsu_pkg;
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    // Low address bits that must be zero for a naturally aligned access of this size.
    function automatic logic [2:0] addr_mask(input logic [1:0] size);
        return 3'b111 >> (2'd3 - size);
    endfunction

    function automatic logic [7:0] lane_mask(input logic [2:0] lane, input logic [1:0] size);
        logic [7:0] base;
        base = size == SZ_D ? 8'hFF : size == SZ_W ? 8'h0F : size == SZ_H ? 8'h03 : 8'h01;
        return base << lane;
    endfunction
endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: extracts the addressed lane of a doubleword and sign/zero-extends it to 64 bits.
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [63:0] buffer,
    input  logic [2:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] result
);
    logic [63:0] s;

    always_comb begin
        s = buffer >> {lane, 3'b000};
        result = size == SZ_B ? {{56{!is_unsigned && s[7]}}, s[7:0]}
               : size == SZ_H ? {{48{!is_unsigned && s[15]}}, s[15:0]}
               : size == SZ_W ? {{32{!is_unsigned && s[31]}}, s[31:0]}
               : s;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for a byte-addressed 64-bit data memory;
// sub-doubleword stores are done as read-modify-write of the containing doubleword.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES   = 64,
    parameter bit CHECK_ALIGN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [63:0] Read_Data
);
    state_t      state, next;
    logic        wr_q, uns_q;
    logic [1:0]  size_q;
    logic [2:0]  lane_q;
    logic [63:0] wdata_q, wshift, bmask, merged, loaded;
    logic [7:0]  lmask;
    logic        accept, misaligned, out_of_range, err;

    assign req_ready    = state == IDLE;
    assign MemRead      = state == RD;
    assign MemWrite     = state == WR;
    assign rsp_valid    = state == RSP;
    assign accept       = req_valid && req_ready;
    assign misaligned   = CHECK_ALIGN && ((req_addr[2:0] & addr_mask(req_size)) != 3'd0);
    // 65-bit sum so addresses near the top of the space cannot wrap into range.
    assign out_of_range = ({1'b0, req_addr[63:3], 3'b000} + 65'd8) > 65'(MEM_BYTES);
    assign err          = misaligned || out_of_range;

    always_comb begin
        next = state == IDLE ? (!accept ? IDLE : err ? RSP : (req_write && req_size == SZ_D) ? WR : RD)
             : state == RD   ? (wr_q ? WR : RSP)
             : state == WR   ? RSP
             : IDLE;
    end

    always_comb begin
        lmask  = lane_mask(lane_q, size_q);
        wshift = wdata_q << {lane_q, 3'b000};
        for (int i = 0; i < 8; i++) bmask[8*i +: 8] = {8{lmask[i]}};
        merged = (Read_Data & ~bmask) | (wshift & bmask);
    end

    load_align_ext u_ext (
        .buffer      (Read_Data),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (loaded)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_B;
            lane_q     <= 3'd0;
            wdata_q    <= 64'd0;
            Mem_Addr   <= 64'd0;
            Write_Data <= 64'd0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                wr_q    <= req_write;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                lane_q  <= req_addr[2:0];
                wdata_q <= req_wdata;
                if (err) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 64'd0;
                end else begin
                    Mem_Addr <= {req_addr[63:3], 3'b000};
                    if (req_write && req_size == SZ_D) Write_Data <= req_wdata;
                end
            end
            if (state == RD && wr_q) Write_Data <= merged;
            if (state == RD && !wr_q) begin
                rsp_rdata <= loaded;
                rsp_err   <= 1'b0;
            end
            if (state == WR) begin
                rsp_rdata <= 64'd0;
                rsp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench with a byte-array memory model (byte i = i+1 at start).
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0, reset_n = 1'b0, init = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = SZ_B;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, MemRead, MemWrite;
    logic [63:0] rsp_rdata, Mem_Addr, Write_Data, Read_Data;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [64];
    int         rd_cnt = 0, wr_cnt = 0, nchk = 0, npass = 0;

    load_store_unit #(.MEM_BYTES(64), .CHECK_ALIGN(1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .Mem_Addr     (Mem_Addr),
        .Write_Data   (Write_Data),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .Read_Data    (Read_Data)
    );

    always #5 clk = ~clk;

    always_comb begin
        Read_Data = '0;
        for (int i = 0; i < 8; i++)
            Read_Data[8*i +: 8] = Mem_Addr < 64 ? mem[Mem_Addr[5:0] | 6'(i)] : 8'h00;
    end

    always @(posedge clk) begin
        if (init) for (int i = 0; i < 64; i++) mem[6'(i)] <= 8'(i + 1);
        else if (MemWrite) for (int i = 0; i < 8; i++) mem[Mem_Addr[5:0] | 6'(i)] <= Write_Data[8*i +: 8];
    end

    always @(posedge clk) begin
        if (MemRead) rd_cnt++;
        if (MemWrite) wr_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic req(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] er,
                       input logic ee, input int lat, input int nrd, input int nwr);
        int   cyc, rd0, wr0;
        exp_t e;
        sb.push_back('{er, ee, lat, nrd, nwr});
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        rd0 = rd_cnt; wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_unsigned = ~u; req_addr = ~a; req_wdata = ~wd;
        cyc = 1;
        while (!rsp_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        e = sb.pop_front();
        check({tag, " latency"}, 64'(cyc), 64'(e.lat));
        check({tag, " rdata"}, rsp_rdata, e.rdata);
        check({tag, " err"}, 64'(rsp_err), 64'(e.err));
        check({tag, " reads"}, 64'(rd_cnt - rd0), 64'(e.nrd));
        check({tag, " writes"}, 64'(wr_cnt - wr0), 64'(e.nwr));
        @(posedge clk); #1;
        check({tag, " pulse end"}, 64'(rsp_valid), 64'd0);
        check({tag, " rdata hold"}, rsp_rdata, e.rdata);
    endtask

    initial begin
        int wr0;
        reset_n = 1'b0; init = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", 64'(req_ready), 64'd1);
        check("rst rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst rsp_err", 64'(rsp_err), 64'd0);
        check("rst rsp_rdata", rsp_rdata, 64'd0);
        check("rst strobes", {62'd0, MemRead, MemWrite}, 64'd0);
        check("rst Mem_Addr", Mem_Addr, 64'd0);
        check("rst Write_Data", Write_Data, 64'd0);
        @(negedge clk); init = 1'b0; reset_n = 1'b1;

        req("ldD0",    0, SZ_D, 0, 64'h00, 0, 64'h0807060504030201, 0, 2, 1, 0);
        req("stB5",    1, SZ_B, 0, 64'h05, 64'h12345678_9ABCDEFF, 64'd0, 0, 3, 1, 1);
        req("ldD0b",   0, SZ_D, 0, 64'h00, 0, 64'h0807FF0504030201, 0, 2, 1, 0);
        req("ldB5s",   0, SZ_B, 0, 64'h05, 0, 64'hFFFFFFFFFFFFFFFF, 0, 2, 1, 0);
        req("ldB5u",   0, SZ_B, 1, 64'h05, 0, 64'h00000000000000FF, 0, 2, 1, 0);
        req("ldHEu",   0, SZ_H, 1, 64'h0E, 0, 64'h000000000000100F, 0, 2, 1, 0);
        req("stD8",    1, SZ_D, 0, 64'h08, 64'h1122334455667788, 64'd0, 0, 2, 0, 1);
        req("ldD8",    0, SZ_D, 1, 64'h08, 0, 64'h1122334455667788, 0, 2, 1, 0);
        req("stW18",   1, SZ_W, 0, 64'h18, 64'hFFFFFFFF_89ABCDEF, 64'd0, 0, 3, 1, 1);
        req("ldW18s",  0, SZ_W, 0, 64'h18, 0, 64'hFFFFFFFF89ABCDEF, 0, 2, 1, 0);
        req("ldD18",   0, SZ_D, 0, 64'h18, 0, 64'h201F1E1D89ABCDEF, 0, 2, 1, 0);
        req("stH22",   1, SZ_H, 0, 64'h22, 64'h0000_0000_0000_BEEF, 64'd0, 0, 3, 1, 1);
        req("ldD20",   0, SZ_D, 0, 64'h20, 0, 64'h28272625BEEF2221, 0, 2, 1, 0);
        req("ldW2err", 0, SZ_W, 0, 64'h02, 0, 64'd0, 1, 1, 0, 0);
        req("ldD40err",0, SZ_D, 0, 64'h40, 0, 64'd0, 1, 1, 0, 0);
        req("stH3Ferr",1, SZ_H, 0, 64'h3F, 64'hAAAA, 64'd0, 1, 1, 0, 0);
        req("ldD38",   0, SZ_D, 0, 64'h38, 0, 64'h403F3E3D3C3B3A39, 0, 2, 1, 0);

        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = 64'h10; req_wdata = 64'hDEADBEEF;
        wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort in WR", 64'(MemWrite), 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort strobe drop", 64'(MemWrite), 64'd0);
        check("abort ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort no rsp", 64'(rsp_valid), 64'd0);
        end
        check("abort no write", 64'(wr_cnt - wr0), 64'd0);
        req("ldW10u", 0, SZ_W, 1, 64'h10, 0, 64'h0000000014131211, 0, 2, 1, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
